// File: rtl/pci_chk_par.sv
// Receive-side PCI parity checker: checks even parity of AD/C/BE# against PAR,
// drives PERR# and keeps the Detected Parity Error bit. Define PCI_PERR_CNT_EN for err_cnt.
module pci_chk_par (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adi,
  input  logic [3:0]  cbei,
  input  logic        pari,
  input  logic        data_vld,
  input  logic        perr_en,
  input  logic        dpe_clr,
  output logic        perr_n_o,
  output logic        perr_oe,
  output logic        dpe,
  output logic        par_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_DEHIGH = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   calc_par_p1_q, calc_par_p1_d;
  logic   vld_p1_q, vld_p1_d;
  logic   par_err_q, par_err_d;
  logic   dpe_q, dpe_d;
  logic   perr_n_q, perr_n_d;
  logic   perr_oe_q, perr_oe_d;
  logic   mismatch_p1;
  logic   respond_p1;

  function automatic logic even_par(input logic [31:0] ad, input logic [3:0] cbe);
    return ^{ad, cbe};
  endfunction

  always_comb begin
    calc_par_p1_d = calc_par_p1_q;
    vld_p1_d      = data_vld;
    mismatch_p1   = 1'b0;
    respond_p1    = 1'b0;
    par_err_d     = 1'b0;
    dpe_d         = dpe_q;
    state_d       = state_q;
    perr_n_d      = 1'b1;
    perr_oe_d     = 1'b0;

    // Stage 1: capture parity of the completed data phase
    if (data_vld) begin
      calc_par_p1_d = even_par(adi, cbei);
    end

    // Stage 2: PAR arrives one clock after the data phase
    mismatch_p1 = vld_p1_q & (calc_par_p1_q ^ pari);
    respond_p1  = mismatch_p1 & perr_en;
    par_err_d   = mismatch_p1;
    dpe_d       = mismatch_p1 | (dpe_q & ~dpe_clr);

    case (state_q)
      ST_IDLE:   state_d = respond_p1 ? ST_ASSERT : ST_IDLE;
      ST_ASSERT: state_d = respond_p1 ? ST_ASSERT : ST_DEHIGH;
      ST_DEHIGH: state_d = respond_p1 ? ST_ASSERT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // PERR# pins are flopped from the next state so they carry no input path
    perr_n_d  = (state_d != ST_ASSERT);
    perr_oe_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      calc_par_p1_q <= 1'b0;
      vld_p1_q      <= 1'b0;
      par_err_q     <= 1'b0;
      dpe_q         <= 1'b0;
      perr_n_q      <= 1'b1;
      perr_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      calc_par_p1_q <= calc_par_p1_d;
      vld_p1_q      <= vld_p1_d;
      par_err_q     <= par_err_d;
      dpe_q         <= dpe_d;
      perr_n_q      <= perr_n_d;
      perr_oe_q     <= perr_oe_d;
    end
  end

  assign perr_n_o = perr_n_q;
  assign perr_oe  = perr_oe_q;
  assign dpe      = dpe_q;
  assign par_err  = par_err_q;

`ifdef PCI_PERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // A clear coinciding with a new error leaves that error counted
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (dpe_clr) begin
      err_cnt_d = mismatch_p1 ? 8'd1 : 8'd0;
    end else if (mismatch_p1) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pci_chk_par.sv
// Bench for pci_chk_par: directed and random data phases checked against a
// per-clock timeline model of parity error, PERR#, dpe and err_cnt.
module tb_pci_chk_par;
  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst, data_vld, perr_en, dpe_clr, pari;
  logic [31:0] adi;
  logic [3:0]  cbei;
  logic        perr_n_o, perr_oe, dpe, par_err;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic v_a[N], cp_a[N], p_a[N], en_a[N], clr_a[N], r_a[N];
  logic epe[N], elow[N], edpe[N];
  int   ecnt[N];
  logic en_g     = 1'b1;
  logic par_next = 1'b0;

  always #5 clk = ~clk;

  pci_chk_par dut (
    .clk(clk), .rst(rst), .adi(adi), .cbei(cbei), .pari(pari),
    .data_vld(data_vld), .perr_en(perr_en), .dpe_clr(dpe_clr),
    .perr_n_o(perr_n_o), .perr_oe(perr_oe), .dpe(dpe),
    .par_err(par_err), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Inputs for the current clock; PAR always belongs to the previous clock's phase.
  task automatic drive(input logic vld, input logic [31:0] ad, input logic [3:0] cbe,
                       input logic bad, input logic clr, input logic rs);
    data_vld = vld; adi = ad; cbei = cbe; pari = par_next;
    perr_en = en_g; dpe_clr = clr; rst = rs;
    v_a[cyc] = vld; cp_a[cyc] = ^{ad, cbe}; p_a[cyc] = par_next;
    en_a[cyc] = en_g; clr_a[cyc] = clr; r_a[cyc] = rs;
    par_next = vld ? (^{ad, cbe} ^ bad) : 1'($urandom_range(0, 1));
  endtask

  // Advance one clock and compare every output seen during the new clock.
  task automatic tick();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc;
    if (k < 2) begin
      epe[k] = 1'b0; elow[k] = 1'b0; edpe[k] = 1'b0; ecnt[k] = 0;
    end else begin
      epe[k]  = !r_a[k-1] && !r_a[k-2] && v_a[k-2] && (cp_a[k-2] ^ p_a[k-1]);
      elow[k] = epe[k] && en_a[k-1];
      edpe[k] = r_a[k-1] ? 1'b0 : (epe[k] || (edpe[k-1] && !clr_a[k-1]));
`ifdef PCI_PERR_CNT_EN
      if (r_a[k-1])       ecnt[k] = 0;
      else if (clr_a[k-1]) ecnt[k] = epe[k] ? 1 : 0;
      else if (epe[k])     ecnt[k] = (ecnt[k-1] >= 255) ? 255 : ecnt[k-1] + 1;
      else                 ecnt[k] = ecnt[k-1];
`else
      ecnt[k] = 0;
`endif
      chk("par_err",  {7'd0, par_err},  {7'd0, epe[k]});
      chk("perr_n_o", {7'd0, perr_n_o}, {7'd0, !elow[k]});
      chk("perr_oe",  {7'd0, perr_oe},  {7'd0, elow[k] || (elow[k-1] && !r_a[k-1])});
      chk("dpe",      {7'd0, dpe},      {7'd0, edpe[k]});
      chk("err_cnt",  err_cnt,          8'(ecnt[k]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, $urandom, 4'($urandom), 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic err_phase(input logic bad);
    drive(1'b1, 32'h0000_0001, 4'h0, bad, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    // Reset
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1); tick();
    chk("rst_perr_oe", {7'd0, perr_oe}, 8'd0);
    chk("rst_perr_n",  {7'd0, perr_n_o}, 8'd1);
    chk("rst_dpe",     {7'd0, dpe}, 8'd0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    idle(2);

    // Good parity
    err_phase(1'b0); idle(4);
    chk("good_dpe", {7'd0, dpe}, 8'd0);

    // Single error with response enabled: clocks N+2, N+3, N+4
    err_phase(1'b1); idle(1);
    chk("single_low",    {7'd0, perr_n_o}, 8'd0);
    chk("single_parerr", {7'd0, par_err}, 8'd1);
    idle(1);
    chk("single_dehigh", {perr_oe, perr_n_o} == 2'b11 ? 8'd1 : 8'd0, 8'd1);
    idle(1);
    chk("single_release", {7'd0, perr_oe}, 8'd0);
    idle(2);

    // Response disabled
    en_g = 1'b0;
    err_phase(1'b1); idle(5);
    en_g = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0); tick();

    // Back-to-back errors, then an error landing in DEHIGH
    err_phase(1'b1); err_phase(1'b1); idle(5);
    err_phase(1'b1); idle(1); err_phase(1'b1); idle(5);

    // Clear race: dpe_clr in the clock where the mismatch is detected
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0); tick();
    err_phase(1'b1);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0); tick();
    chk("race_dpe", {7'd0, dpe}, 8'd1);
    idle(3);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0); tick();
    chk("clr_dpe", {7'd0, dpe}, 8'd0);
    chk("clr_cnt", err_cnt, 8'h00);

    // Saturation
    en_g = 1'b0;
    for (int i = 0; i < 300; i++) err_phase(1'b1);
    idle(3);
    en_g = 1'b1;
`ifdef PCI_PERR_CNT_EN
    chk("sat_cnt", err_cnt, 8'hFF);
`else
    chk("sat_cnt", err_cnt, 8'h00);
`endif

    // Reset while PERR# is low, with a stage-1 check pending
    err_phase(1'b1); idle(1);
    chk("pre_rst_low", {7'd0, perr_n_o}, 8'd0);
    drive(1'b1, 32'hDEAD_BEEF, 4'h5, 1'b1, 1'b0, 1'b1); tick();
    chk("rst_mid_oe",  {7'd0, perr_oe}, 8'd0);
    chk("rst_mid_n",   {7'd0, perr_n_o}, 8'd1);
    chk("rst_mid_dpe", {7'd0, dpe}, 8'd0);
    idle(1);
    chk("rst_mid_noerr", {7'd0, par_err}, 8'd0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      en_g = ($urandom_range(0, 7) != 0);
      drive(1'($urandom_range(0, 2) != 0), $urandom, 4'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 99) == 0));
      tick();
    end
    en_g = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
